// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, functs,
// FSM states, datapath select codes and the decoded instruction-class bundle.
package mips_pkg;

  localparam int unsigned OP_W  = 6;
  localparam int unsigned FN_W  = 6;
  localparam int unsigned ALU_W = 3;

  // primary opcodes
  localparam logic [OP_W-1:0] OP_SPECIAL = 6'b000000;
  localparam logic [OP_W-1:0] OP_ORI     = 6'b001101;
  localparam logic [OP_W-1:0] OP_LW      = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW      = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ     = 6'b000100;
  localparam logic [OP_W-1:0] OP_LUI     = 6'b001111;
  localparam logic [OP_W-1:0] OP_J       = 6'b000010;
  localparam logic [OP_W-1:0] OP_JAL     = 6'b000011;

  // SPECIAL funct codes
  localparam logic [FN_W-1:0] FN_ADDU = 6'b100001;
  localparam logic [FN_W-1:0] FN_SUBU = 6'b100011;
  localparam logic [FN_W-1:0] FN_JR   = 6'b001000;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  // immediate extender modes
  localparam logic [1:0] EOP_SIGN  = 2'b00;
  localparam logic [1:0] EOP_ZERO  = 2'b01;
  localparam logic [1:0] EOP_LUI   = 2'b10;
  localparam logic [1:0] EOP_SIGN2 = 2'b11;

  // next-PC sources
  localparam logic [1:0] NPC_PC4 = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  localparam logic [1:0] NPC_JR  = 2'b11;

  // register-file destination and write-data selects
  localparam logic [1:0] RD_RT  = 2'b00;
  localparam logic [1:0] RD_RD  = 2'b01;
  localparam logic [1:0] RD_RA  = 2'b10;
  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_DM  = 2'b01;
  localparam logic [1:0] WD_PC4 = 2'b10;

  // ALU functions
  localparam logic [ALU_W-1:0] ALU_ADD   = 3'b000;
  localparam logic [ALU_W-1:0] ALU_SUB   = 3'b001;
  localparam logic [ALU_W-1:0] ALU_OR    = 3'b010;
  localparam logic [ALU_W-1:0] ALU_PASSB = 3'b011;

  // one-hot instruction class
  typedef struct packed {
    logic addu;
    logic subu;
    logic ori;
    logic lw;
    logic sw;
    logic beq;
    logic lui;
    logic j;
    logic jal;
    logic jr;
    logic nop;
  } iclass_t;

  function automatic logic [OP_W-1:0] opcode_of(input logic [31:0] ins);
    return ins[31:26];
  endfunction

  function automatic logic [FN_W-1:0] funct_of(input logic [31:0] ins);
    return ins[5:0];
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder: IR word -> one-hot class, plus a flag
// for any encoding outside the supported subset.
module mc_decode
  import mips_pkg::*;
(
  input  logic [31:0] instr,
  output iclass_t     cls,
  output logic        is_illegal
);

  logic [OP_W-1:0] op;
  logic [FN_W-1:0] fn;

  assign op = opcode_of(instr);
  assign fn = funct_of(instr);

  // classify; the all-zero word is nop and takes priority over SPECIAL decode
  always_comb begin
    cls = '0;
    if (instr == 32'h0000_0000) begin
      cls.nop = 1'b1;
    end else begin
      case (op)
        OP_SPECIAL: begin
          case (fn)
            FN_ADDU: cls.addu = 1'b1;
            FN_SUBU: cls.subu = 1'b1;
            FN_JR:   cls.jr   = 1'b1;
            default: cls      = '0;
          endcase
        end
        OP_ORI:  cls.ori = 1'b1;
        OP_LW:   cls.lw  = 1'b1;
        OP_SW:   cls.sw  = 1'b1;
        OP_BEQ:  cls.beq = 1'b1;
        OP_LUI:  cls.lui = 1'b1;
        OP_J:    cls.j   = 1'b1;
        OP_JAL:  cls.jal = 1'b1;
        default: cls     = '0;
      endcase
    end
  end

  assign is_illegal = (cls == '0);

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB/HALT).
// Optional macro MC_CTRL_MEM_WAIT_EN: adds mem_ready handshake in MEM with a
// MEM_TIMEOUT-cycle watchdog that sends the FSM to HALT.
module mc_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned ALUOP_W = 3
`ifdef MC_CTRL_MEM_WAIT_EN
  ,
  parameter int unsigned MEM_TIMEOUT = 15
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        instr,
  input  logic               zero,
`ifdef MC_CTRL_MEM_WAIT_EN
  input  logic               mem_ready,
`endif
  output logic [2:0]         state,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic [1:0]         NPCOp,
  output logic [1:0]         EOp,
  output logic               ALUSrc,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [1:0]         RegDst,
  output logic [1:0]         WDSel,
  output logic               RegWrite,
  output logic               MemWrite,
  output logic               instr_done,
  output logic               illegal
);

  state_t  cur_st;
  state_t  nxt_st;
  iclass_t cls;
  logic    dec_illegal;
  logic    mem_ok;
  logic    mem_timeout;

  mc_decode u_decode (
    .instr      (instr),
    .cls        (cls),
    .is_illegal (dec_illegal)
  );

`ifdef MC_CTRL_MEM_WAIT_EN
  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1) + 1;

  logic [CNT_W-1:0] wait_cnt;

  // count MEM cycles; cleared whenever outside MEM so each MEM visit starts at zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (cur_st != S_MEM) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  assign mem_ok      = mem_ready;
  assign mem_timeout = (MEM_TIMEOUT != 0) && (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));
`else
  assign mem_ok      = 1'b1;
  assign mem_timeout = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_st <= S_FETCH;
    end else begin
      cur_st <= nxt_st;
    end
  end

  // next-state logic
  always_comb begin
    nxt_st = cur_st;
    case (cur_st)
      S_FETCH: nxt_st = S_DECODE;
      S_DECODE: begin
        if (dec_illegal)                   nxt_st = S_HALT;
        else if (cls.j || cls.jr || cls.nop) nxt_st = S_FETCH;
        else if (cls.jal)                  nxt_st = S_WB;
        else                               nxt_st = S_EXEC;
      end
      S_EXEC: begin
        if (cls.lw || cls.sw)                               nxt_st = S_MEM;
        else if (cls.addu || cls.subu || cls.ori || cls.lui) nxt_st = S_WB;
        else                                                nxt_st = S_FETCH;
      end
      S_MEM: begin
        if (mem_ok)           nxt_st = cls.lw ? S_WB : S_FETCH;
        else if (mem_timeout) nxt_st = S_HALT;
        else                  nxt_st = S_MEM;
      end
      S_WB:    nxt_st = S_FETCH;
      S_HALT:  nxt_st = S_HALT;
      default: nxt_st = S_FETCH;
    endcase
  end

  // Moore outputs qualified by instruction class; everything quiet while reset is high
  always_comb begin
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    NPCOp      = NPC_PC4;
    EOp        = EOP_SIGN;
    ALUSrc     = 1'b0;
    ALUOp      = ALUOP_W'(ALU_ADD);
    RegDst     = RD_RT;
    WDSel      = WD_ALU;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    instr_done = 1'b0;

    if (!reset) begin
      // ALU and extender selects are set up in EXEC and held through MEM
      if (cur_st == S_EXEC || cur_st == S_MEM) begin
        if (cls.subu) begin
          ALUOp = ALUOP_W'(ALU_SUB);
        end else if (cls.ori) begin
          EOp    = EOP_ZERO;
          ALUSrc = 1'b1;
          ALUOp  = ALUOP_W'(ALU_OR);
        end else if (cls.lw || cls.sw) begin
          ALUSrc = 1'b1;
        end else if (cls.lui) begin
          EOp    = EOP_LUI;
          ALUSrc = 1'b1;
          ALUOp  = ALUOP_W'(ALU_PASSB);
        end else if (cls.beq) begin
          EOp   = EOP_SIGN2;
          ALUOp = ALUOP_W'(ALU_SUB);
        end
      end

      case (cur_st)
        S_FETCH: begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
        end
        S_DECODE: begin
          if (cls.j || cls.jal) begin
            PCWrite = 1'b1;
            NPCOp   = NPC_J;
          end else if (cls.jr) begin
            PCWrite = 1'b1;
            NPCOp   = NPC_JR;
          end
          instr_done = cls.j || cls.jr || cls.nop;
        end
        S_EXEC: begin
          if (cls.beq) begin
            PCWrite    = zero;
            NPCOp      = NPC_BR;
            instr_done = 1'b1;
          end
        end
        S_MEM: begin
          MemWrite   = cls.sw;
          instr_done = cls.sw && mem_ok;
        end
        S_WB: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
          if (cls.addu || cls.subu) begin
            RegDst = RD_RD;
          end else if (cls.lw) begin
            WDSel = WD_DM;
          end else if (cls.jal) begin
            RegDst = RD_RA;
            WDSel  = WD_PC4;
          end
        end
        default: ;
      endcase
    end
  end

  assign state   = 3'(cur_st);
  assign illegal = (cur_st == S_HALT);

endmodule
